// File: rtl/gj_row_sequencer.sv
// gj_row_sequencer: orders Gauss-Jordan NORM/ELIM row commands for a shared row engine.
// Define GJ_PERF_CNT_EN to add the cyc_cnt_o/stall_cnt_o performance counters.
module gj_row_sequencer #(
    parameter int N       = 5,
    parameter int ROW_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic             cmd_op_o,
    output logic [ROW_W-1:0] cmd_pivot_o,
    output logic [ROW_W-1:0] cmd_target_o,
    input  logic             rsp_valid_i,
    input  logic             rsp_zero_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [ROW_W-1:0] err_row_o
`ifdef GJ_PERF_CNT_EN
    ,
    output logic [15:0]      cyc_cnt_o,
    output logic [15:0]      stall_cnt_o
`endif
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ROW_W:0] ONE_X = 1;
    localparam logic [ROW_W:0] N_X = (ROW_W + 1)'(N);
    localparam logic [ROW_W:0] LAST_X = (ROW_W + 1)'(N - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [ROW_W-1:0] k_q, k_d;
    logic [ROW_W-1:0] i_q, i_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [ROW_W-1:0] err_row_q, err_row_d;
    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
    logic [ROW_W:0]   cand, nxt;
    logic             wrap, last_k, start_go;

    // Next ELIM target after the current command, skipping the pivot row; wrap means k is finished.
    always_comb begin
        cand = op_q ? ({1'b0, i_q} + ONE_X) : '0;
        nxt = (cand == {1'b0, k_q}) ? cand + ONE_X : cand;
        wrap = nxt >= N_X;
        last_k = {1'b0, k_q} == LAST_X;
        wd_inc = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        start_go = start_i && !abort_i && (state_q inside {IDLE, DONE, ERR});
    end

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        k_d = k_q;
        i_d = i_q;
        wd_d = wd_q;
        err_code_d = err_code_q;
        err_row_d = err_row_q;
        if (abort_i) begin
            state_d = IDLE;
            err_code_d = '0;
            err_row_d = '0;
        end else if (start_go) begin
            state_d = ISSUE;
            op_d = 1'b0;
            k_d = '0;
            i_d = '0;
            err_code_d = '0;
            err_row_d = '0;
        end else begin
            case (state_q)
                DONE: state_d = IDLE;
                ISSUE: begin
                    if (cmd_ready_i) begin
                        state_d = WAIT;
                        wd_d = '0;
                    end
                end
                WAIT: begin
                    wd_d = wd_inc;
                    if (rsp_valid_i) begin
                        if (!op_q && rsp_zero_i) begin
                            state_d = ERR;
                            err_code_d = 2'd1;
                            err_row_d = k_q;
                        end else if (wrap && last_k) begin
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE;
                            op_d = !wrap;
                            k_d = wrap ? k_q + ROW_W'(1) : k_q;
                            i_d = wrap ? k_q + ROW_W'(1) : nxt[ROW_W-1:0];
                        end
                    end else if (wd_inc == WD_W'(TIMEOUT)) begin
                        state_d = ERR;
                        err_code_d = 2'd2;
                        err_row_d = k_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= 1'b0;
            k_q <= '0;
            i_q <= '0;
            wd_q <= '0;
            err_code_q <= '0;
            err_row_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            k_q <= k_d;
            i_q <= i_d;
            wd_q <= wd_d;
            err_code_q <= err_code_d;
            err_row_q <= err_row_d;
        end
    end

    assign cmd_valid_o = state_q == ISSUE;
    assign busy_o = (state_q == ISSUE) || (state_q == WAIT);
    assign done_o = state_q == DONE;
    assign err_o = state_q == ERR;
    assign cmd_op_o = op_q;
    assign cmd_pivot_o = k_q;
    assign cmd_target_o = i_q;
    assign err_code_o = err_code_q;
    assign err_row_o = err_row_q;

`ifdef GJ_PERF_CNT_EN
    logic [15:0] cyc_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            stall_q <= '0;
        end else if (start_go) begin
            cyc_q <= '0;
            stall_q <= '0;
        end else begin
            if (busy_o && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
            if (cmd_valid_o && !cmd_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign cyc_cnt_o = cyc_q;
    assign stall_cnt_o = stall_q;
`endif
endmodule
